// File: rtl/phase_timer.sv
// phase_timer: prescaled interval timer that answers the sequencer's start/done handshake.
// Optional macro PHASE_TIMER_PAUSE_EN adds a timer_pause input that freezes the countdown in RUN.
`timescale 1ns/1ps
module phase_timer #(
   parameter int unsigned TICK_DIV    = 50_000_000,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned SHORT_TICKS = 3,
   parameter int unsigned MED_TICKS   = 10,
   parameter int unsigned LONG_TICKS  = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             timer_start,
   input  logic [1:0]       duration_sel,
`ifdef PHASE_TIMER_PAUSE_EN
   input  logic             timer_pause,
`endif
   output logic             timer_done,
   output logic [CNT_W-1:0] remaining,
   output logic             tick
);

   localparam int unsigned      PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] SHORT_CNT = CNT_W'(SHORT_TICKS);
   localparam logic [CNT_W-1:0] MED_CNT   = CNT_W'(MED_TICKS);
   localparam logic [CNT_W-1:0] LONG_CNT  = CNT_W'(LONG_TICKS);
   localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_ARM,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             done_q, done_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] load_cnt;
   logic             pause_w;

   // 2'b11 is an unused encoding and falls back to the short interval
   function automatic logic [CNT_W-1:0] decode_ticks(input logic [1:0] sel);
      case (sel)
         2'b01:   return MED_CNT;
         2'b10:   return LONG_CNT;
         default: return SHORT_CNT;
      endcase
   endfunction

`ifdef PHASE_TIMER_PAUSE_EN
   assign pause_w = timer_pause;
`else
   assign pause_w = 1'b0;
`endif

   assign load_cnt = decode_ticks(duration_sel);

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      rem_d   = rem_q;
      done_d  = done_q;
      tick_d  = 1'b0;
      if (timer_start) begin
         state_d = ST_ARM;
         pre_d   = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            ST_ARM: begin
               // duration_sel is taken here, one cycle after the start pulse
               pre_d = '0;
               if (load_cnt == '0) begin
                  state_d = ST_DONE;
                  rem_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  rem_d   = load_cnt;
               end
            end
            ST_RUN: begin
               if (!pause_w) begin
                  if (pre_q == PRE_LAST) begin
                     pre_d  = '0;
                     tick_d = 1'b1;
                     if (rem_q <= ONE_CNT) begin
                        rem_d   = '0;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                     end else begin
                        rem_d = rem_q - ONE_CNT;
                     end
                  end else begin
                     pre_d = pre_q + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               pre_d  = '0;
               rem_d  = '0;
               done_d = 1'b1;
            end
            default: begin
               state_d = ST_RUN;
               pre_d   = '0;
            end
         endcase
      end
   end

   // Reset lands in RUN so the post-reset all-red interval times out unprompted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         pre_q   <= '0;
         rem_q   <= SHORT_CNT;
         done_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         tick_q  <= tick_d;
      end
   end

   assign timer_done = done_q;
   assign remaining  = rem_q;
   assign tick       = tick_q;

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer: directed scenarios plus randomized start/select traffic.
`timescale 1ns/1ps
module tb_phase_timer;

   localparam int TD = 4;
   localparam int SH = 3;
   localparam int MD = 5;
   localparam int LG = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          timer_start;
   logic [1:0]    duration_sel;
   logic          timer_pause;
   logic          timer_done;
   logic [CW-1:0] remaining;
   logic          tick;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   phase_timer #(
      .TICK_DIV   (TD),
      .CNT_W      (CW),
      .SHORT_TICKS(SH),
      .MED_TICKS  (MD),
      .LONG_TICKS (LG)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .timer_start (timer_start),
      .duration_sel(duration_sel),
`ifdef PHASE_TIMER_PAUSE_EN
      .timer_pause (timer_pause),
`endif
      .timer_done  (timer_done),
      .remaining   (remaining),
      .tick        (tick)
   );

   // Reference: the interval is N ticks of TD cycles; track elapsed running cycles since load.
   bit m_arm;
   int m_n;
   int m_el;
   int m_hold;
   bit m_tk;

   function automatic int dec(input logic [1:0] s);
      if (s == 2'b01) return MD;
      if (s == 2'b10) return LG;
      return SH;
   endfunction

   function automatic int m_rem();
      return m_arm ? m_hold : (m_n - m_el / TD);
   endfunction

   function automatic bit m_done();
      return !m_arm && (m_el == m_n * TD);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_arm  <= 1'b0;
         m_n    <= SH;
         m_el   <= 0;
         m_tk   <= 1'b0;
         m_hold <= SH;
      end else if (timer_start) begin
         m_hold <= m_rem();
         m_arm  <= 1'b1;
         m_tk   <= 1'b0;
      end else if (m_arm) begin
         m_arm <= 1'b0;
         m_n   <= dec(duration_sel);
         m_el  <= 0;
         m_tk  <= 1'b0;
      end else if (m_el < m_n * TD && !timer_pause) begin
         m_el <= m_el + 1;
         m_tk <= ((m_el + 1) % TD == 0);
      end else begin
         m_tk <= 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("cyc_done", {31'd0, timer_done}, {31'd0, m_done()});
         chk("cyc_rem", {24'd0, remaining}, m_rem());
         chk("cyc_tick", {31'd0, tick}, {31'd0, m_tk});
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n        = 1'b0;
      timer_start  = 1'b0;
      duration_sel = 2'b00;
      timer_pause  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("rst_done", {31'd0, timer_done}, 0);
      chk("rst_rem", {24'd0, remaining}, 3);
      chk("rst_tick", {31'd0, tick}, 0);

      // Boot interval: no start pulse needed
      #2 rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step(1);
         chk("boot_rem", {24'd0, remaining}, 3 - k / 4);
         chk("boot_tick", {31'd0, tick}, (k % 4 == 0) ? 1 : 0);
         chk("boot_done", {31'd0, timer_done}, (k == 12) ? 1 : 0);
      end

      // Select changes between start and ARM: the ARM-cycle value wins
      timer_start = 1'b1; duration_sel = 2'b00;
      step(1);
      chk("long_start_done", {31'd0, timer_done}, 0);
      timer_start = 1'b0; duration_sel = 2'b10;
      step(1);
      chk("long_load", {24'd0, remaining}, 8);
      duration_sel = 2'($urandom_range(0, 3));
      step(31);
      chk("long_early", {31'd0, timer_done}, 0);
      step(1);
      chk("long_done", {31'd0, timer_done}, 1);
      chk("long_rem0", {24'd0, remaining}, 0);

      // Start from DONE with the unused select code
      timer_start = 1'b1;
      step(1);
      chk("sel3_start_done", {31'd0, timer_done}, 0);
      timer_start = 1'b0; duration_sel = 2'b11;
      step(1);
      chk("sel3_load", {24'd0, remaining}, 3);
      step(11);
      chk("sel3_early", {31'd0, timer_done}, 0);
      step(1);
      chk("sel3_done", {31'd0, timer_done}, 1);

      // Restart in the middle of a MED run
      timer_start = 1'b1;
      step(1);
      timer_start = 1'b0; duration_sel = 2'b01;
      step(1);
      chk("med_load", {24'd0, remaining}, 5);
      step(8);
      timer_start = 1'b1;
      step(1);
      timer_start = 1'b0;
      step(1);
      chk("med_reload", {24'd0, remaining}, 5);
      step(10);
      chk("med_no_done_e21", {31'd0, timer_done}, 0);
      step(10);
      chk("med_done_e31", {31'd0, timer_done}, 1);

      // Start on the same edge as the final tick, then held for extra cycles
      timer_start = 1'b1;
      step(1);
      timer_start = 1'b0; duration_sel = 2'b00;
      step(1);
      step(11);
      chk("race_pre_rem", {24'd0, remaining}, 1);
      timer_start = 1'b1;
      step(1);
      chk("race_done", {31'd0, timer_done}, 0);
      chk("race_rem", {24'd0, remaining}, 1);
      chk("race_tick", {31'd0, tick}, 0);
      step(2);
      chk("hold_done", {31'd0, timer_done}, 0);
      timer_start = 1'b0; duration_sel = 2'b10;
      step(1);
      chk("hold_load", {24'd0, remaining}, 8);

      // Asynchronous reset pulse between edges mid-RUN
      step(6);
      #1 rst_n = 1'b0;
      #0.5;
      chk("areset_rem", {24'd0, remaining}, 3);
      chk("areset_done", {31'd0, timer_done}, 0);
      chk("areset_tick", {31'd0, tick}, 0);
      #0.5 rst_n = 1'b1;
      step(11);
      chk("areset_early", {31'd0, timer_done}, 0);
      step(1);
      chk("areset_done12", {31'd0, timer_done}, 1);

`ifdef PHASE_TIMER_PAUSE_EN
      // Six paused cycles stretch a SHORT interval by six cycles
      timer_start = 1'b1;
      step(1);
      timer_start = 1'b0; duration_sel = 2'b00;
      step(2);
      timer_pause = 1'b1;
      step(6);
      timer_pause = 1'b0;
      step(10);
      chk("pause_early", {31'd0, timer_done}, 0);
      step(1);
      chk("pause_done", {31'd0, timer_done}, 1);
`endif

      for (int i = 0; i < 600; i++) begin
         timer_start  = ($urandom_range(0, 13) == 0);
         duration_sel = 2'($urandom_range(0, 3));
`ifdef PHASE_TIMER_PAUSE_EN
         timer_pause  = ($urandom_range(0, 5) == 0);
`endif
         step(1);
      end
      timer_start = 1'b0;
      timer_pause = 1'b0;
      step(40);
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/phase_timer.md
Name: phase_timer

Overview:
- Interval timer on the responder side of the traffic-light controller's timer handshake.
- The sequencer FSM pulses timer_start and drives duration_sel combinationally from its current state. This block counts the selected interval in prescaled ticks and returns timer_done.
- Also exports the remaining tick count and a tick strobe for countdown displays and blink logic.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per tick; must be >= 2.
- CNT_W, 8: width of the tick counter and the remaining output.
- SHORT_TICKS, 3: ticks for duration_sel 2'b00 (yellow / all-red).
- MED_TICKS, 10: ticks for duration_sel 2'b01 (side green).
- LONG_TICKS, 20: ticks for duration_sel 2'b10 (main green).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- timer_start  input  1  one-cycle restart request from sequencer
- duration_sel  input  2  interval select; 2'b11 is treated as 2'b00
- timer_done  output  1  registered level; high while interval expired
- remaining  output  CNT_W  ticks left in current interval
- tick  output  1  registered one-cycle pulse per prescaler wrap while running

Behaviour:
- Clock, reset, polarity (decided): one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- States: ARM, RUN, DONE. Encoding is an implementation choice.
- Reset values:
  - State RUN, prescaler 0, remaining = SHORT_TICKS.
  - timer_done 0, tick 0.
  - Effect: the sequencer's post-reset all-red interval elapses without needing a start pulse.
- Start handling:
  - timer_start=1 at any edge, in any state (ARM, RUN, DONE), moves the block to ARM.
  - timer_done goes 0 on that same edge, and prescaler and tick are cleared.
  - A start pulse during RUN aborts and restarts the interval.
- ARM (exactly one cycle unless timer_start is high again):
  - Samples duration_sel on this cycle, not on the start cycle. This is intentional: the sequencer has already changed state, so duration_sel now reflects the new phase.
  - Loads remaining with the decoded tick count, prescaler with 0, and moves to RUN.
  - A decoded count of 0 goes straight to DONE with timer_done=1.
- RUN:
  - prescaler increments each cycle.
  - On the edge where prescaler==TICK_DIV-1: prescaler returns to 0, tick=1 for one cycle, and remaining decrements.
  - If remaining was 1 on that edge, remaining becomes 0, state becomes DONE, and timer_done=1 on the same edge.
- DONE:
  - timer_done stays 1, remaining stays 0, prescaler is idle, tick is 0.
  - Exit only via timer_start or reset.
- Latency: timer_done rises on edge E+1+N*TICK_DIV, where E is the edge that samples timer_start and N is the decoded tick count.
- Widths:
  - Prescaler width is clog2(TICK_DIV).
  - Tick parameters must fit in CNT_W. Values wider than CNT_W are truncated; no saturation logic is provided.
- Simultaneous events:
  - timer_start wins over the expiry tick in the same cycle: the block goes to ARM and timer_done stays 0.
  - timer_start held high for several cycles holds the block in ARM; it loads after the last high cycle.
- Reset mid-operation: asynchronous return to the reset values at any time, including in ARM, RUN or DONE.
- No combinational path from any input to any output.

Optional Feature:
- Macro: PHASE_TIMER_PAUSE_EN.
- When defined:
  - Adds input port timer_pause (1 bit).
  - While timer_pause=1 in RUN, prescaler and remaining freeze and tick is 0.
  - timer_start still overrides pause.
  - Pause has no effect in ARM or DONE.
- When undefined: the port does not exist and the counter always runs in RUN.

Test Plan:
- Bench configuration: TICK_DIV=4, SHORT=3, MED=5, LONG=8.
- Reset release, no start -> timer_done rises at edge 12 after reset release; remaining steps 3,2,1,0; tick pulses at edges 4, 8, 12.
- Start pulse with duration_sel=00, then duration_sel=10 on the ARM cycle -> remaining loads 8; timer_done low at the start edge and high at edge E+33.
- Start in DONE with duration_sel=11 on the ARM cycle -> loaded as SHORT; remaining=3; timer_done at E+13.
- Second start at E+10 during a MED run -> interval restarts; no timer_done at E+21; timer_done at E+31.
- Start coinciding with the final tick -> timer_done stays 0; remaining reloads; DONE is not entered.
- Assert rst_n low mid-RUN for 1 ns between edges -> outputs return immediately to reset values (remaining=3, timer_done=0).
- With PHASE_TIMER_PAUSE_EN defined: pause 6 cycles during a SHORT run -> timer_done delayed to E+19.
